// File: rtl/radix_4_pkg.sv
// Shared definitions for the radix-4 restoring divider: FSM states and sizing helpers.
package radix_4_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DIGITS       = DefaultWidth / 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StIter = 2'd2,
        StDone = 2'd3
    } state_e;

    function automatic int unsigned digits_for(input int unsigned width);
        return width / 2;
    endfunction

endpackage

// File: rtl/radix_4_div_step.sv
// One radix-4 restoring step: picks the largest multiple of the divisor that fits the
// partial remainder and returns that digit with the reduced remainder.
module radix_4_div_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH+1:0] r4_i,
    input  logic [WIDTH+1:0] d1_i,
    input  logic [WIDTH+1:0] d2_i,
    input  logic [WIDTH+1:0] d3_i,
    output logic [1:0]       digit_o,
    output logic [WIDTH-1:0] rem_o
);

    // The reduced remainder is always below the divisor, so WIDTH bits hold it.
    always_comb begin
        digit_o = 2'd0;
        rem_o   = WIDTH'(r4_i);
        if (r4_i >= d3_i) begin
            digit_o = 2'd3;
            rem_o   = WIDTH'(r4_i - d3_i);
        end else if (r4_i >= d2_i) begin
            digit_o = 2'd2;
            rem_o   = WIDTH'(r4_i - d2_i);
        end else if (r4_i >= d1_i) begin
            digit_o = 2'd1;
            rem_o   = WIDTH'(r4_i - d1_i);
        end
    end

endmodule

// File: rtl/radix_4_divider.sv
// Sequential unsigned radix-4 restoring divider, two quotient bits per cycle,
// with a start/ready handshake matching the radix-4 Booth multiplier.
module radix_4_divider
    import radix_4_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready,
    output logic             div_by_zero
);

    localparam int unsigned Digits = digits_for(WIDTH);
    localparam int unsigned CntW   = $clog2(Digits);
    localparam logic [CntW-1:0] LastIter = CntW'(Digits - 1);

    state_e           state_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH+1:0] d1_q, d2_q, d3_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] q_q;
    logic [CntW-1:0]  iter_q;
    logic             ready_q;
    logic             dbz_q;

    logic [WIDTH+1:0] d1_n, d2_n, d3_n;
    logic [WIDTH+1:0] r4;
    logic [1:0]       digit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;

    always_comb begin
        d1_n   = {2'b00, dsr_q};
        d2_n   = {1'b0, dsr_q, 1'b0};
        d3_n   = d1_n + d2_n;
        r4     = {rem_q, dvd_q[WIDTH-1:WIDTH-2]};
        q_next = {q_q[WIDTH-3:0], digit};
    end

    radix_4_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r4_i    (r4),
        .d1_i    (d1_q),
        .d2_i    (d2_q),
        .d3_i    (d3_q),
        .digit_o (digit),
        .rem_o   (rem_next)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            dvd_q   <= '0;
            dsr_q   <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            d3_q    <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            iter_q  <= '0;
            ready_q <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        dvd_q   <= dividend;
                        dsr_q   <= divisor;
                        ready_q <= 1'b0;
                        dbz_q   <= 1'b0;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    d1_q   <= d1_n;
                    d2_q   <= d2_n;
                    d3_q   <= d3_n;
                    iter_q <= '0;
                    if (dsr_q == '0) begin
                        q_q     <= '1;
                        rem_q   <= dvd_q;
                        dbz_q   <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        q_q     <= '0;
                        rem_q   <= '0;
                        state_q <= StIter;
                    end
                end
                StIter: begin
                    rem_q  <= rem_next;
                    q_q    <= q_next;
                    dvd_q  <= {dvd_q[WIDTH-3:0], 2'b00};
                    iter_q <= iter_q + 1'b1;
                    if (iter_q == LastIter) begin
                        ready_q <= 1'b1;
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Result registers double as the outputs; they only mean something while ready is high.
    assign quotient    = q_q;
    assign remainder   = rem_q;
    assign ready       = ready_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_radix_4_divider.sv
// Randomised self-checking bench for radix_4_divider against an arithmetic reference model.
module tb_radix_4_divider;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       ready;
    logic       div_by_zero;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    radix_4_divider #(
        .WIDTH (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .ready       (ready),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain / and %, with the all-ones/dividend convention for a zero divisor.
    function automatic int unsigned ref_q(input int unsigned a, input int unsigned b);
        return (b == 0) ? 32'd255 : a / b;
    endfunction

    function automatic int unsigned ref_r(input int unsigned a, input int unsigned b);
        return (b == 0) ? a : a % b;
    endfunction

    // Wait for ready after the accepting edge; returns edges counted (21 on timeout).
    task automatic wait_ready(input bit scramble, output int unsigned lat);
        lat = 0;
        while (lat <= 20) begin
            @(posedge clock);
            lat++;
            #1;
            if (scramble) begin
                dividend = 8'($urandom);
                divisor  = 8'($urandom);
            end
            if (ready) break;
        end
    endtask

    task automatic do_div(input int unsigned a, input int unsigned b, input int unsigned gap);
        int unsigned lat;
        repeat (gap) @(negedge clock);
        @(negedge clock);
        start    = 1'b1;
        dividend = 8'(a);
        divisor  = 8'(b);
        @(posedge clock);
        #1;
        start = 1'b0;
        check_eq("ready_clear", 32'(ready), 0);
        wait_ready(1'b1, lat);
        check_eq("latency", lat, (b == 0) ? 32'd1 : 32'd5);
        check_eq("quotient", 32'(quotient), ref_q(a, b));
        check_eq("remainder", 32'(remainder), ref_r(a, b));
        check_eq("div_by_zero", 32'(div_by_zero), (b == 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int unsigned lat;
        int unsigned a;
        int unsigned b;
        reset    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check_eq("rst_quotient", 32'(quotient), 0);
        check_eq("rst_remainder", 32'(remainder), 0);
        check_eq("rst_ready", 32'(ready), 0);
        check_eq("rst_dbz", 32'(div_by_zero), 0);
        @(negedge clock);
        reset = 1'b1;

        // Directed cases
        do_div(200, 7, 0);
        do_div(255, 1, 1);
        do_div(0, 9, 0);
        do_div(13, 200, 2);
        do_div(5, 0, 0);

        // Asynchronous reset in the middle of an iteration
        @(negedge clock);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd3;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check_eq("midrst_quotient", 32'(quotient), 0);
        check_eq("midrst_remainder", 32'(remainder), 0);
        check_eq("midrst_ready", 32'(ready), 0);
        check_eq("midrst_dbz", 32'(div_by_zero), 0);
        @(negedge clock);
        reset = 1'b1;
        do_div(100, 3, 0);

        // Start held high from DONE restarts; later operand changes are ignored
        @(negedge clock);
        start    = 1'b1;
        dividend = 8'd77;
        divisor  = 8'd5;
        @(posedge clock);
        #1;
        check_eq("b2b_ready_drop", 32'(ready), 0);
        wait_ready(1'b1, lat);
        start = 1'b0;
        check_eq("b2b_latency", lat, 5);
        check_eq("b2b_quotient", 32'(quotient), 15);
        check_eq("b2b_remainder", 32'(remainder), 2);

        // Corner sweeps
        for (int i = 0; i < 256; i++) do_div(255, 32'(i), 0);
        for (int i = 0; i < 256; i++) do_div(32'(i), 1, 0);
        for (int i = 0; i < 256; i++) do_div(32'(i), 32'(i), 0);

        // Random pairs with random start gaps, small divisors weighted in
        for (int k = 0; k < 3000; k++) begin
            a = $urandom_range(0, 255);
            b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 255);
            do_div(a, b, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
